// File: rtl/traffic_light_junction.sv
// traffic_light_junction: two-road junction controller with pedestrian walk insertion; define TL_FLASH_IDLE_EN for flashing-yellow idle
module traffic_light_junction #(
  parameter int CNT_W        = 8,
  parameter int GREEN_T      = 20,
  parameter int YELLOW_T     = 4,
  parameter int ALL_RED_T    = 2,
  parameter int WALK_T       = 10,
  parameter int FLASH_HALF_T = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);
  localparam logic [2:0] IDLE = 3'd0, NS_G = 3'd1, NS_Y = 3'd2, AR1 = 3'd3,
                         EW_G = 3'd4, EW_Y = 3'd5, AR2 = 3'd6, WALK = 3'd7;
  if (GREEN_T < 1 || GREEN_T >= 2**CNT_W || YELLOW_T < 1 || YELLOW_T >= 2**CNT_W ||
      ALL_RED_T < 1 || ALL_RED_T >= 2**CNT_W || WALK_T < 1 || WALK_T >= 2**CNT_W ||
      FLASH_HALF_T < 1 || FLASH_HALF_T >= 2**CNT_W) begin : g_bad_len
    $error("traffic_light_junction: phase length outside 1..2^CNT_W-1");
  end
  logic [2:0] state, nxt;
  logic [CNT_W-1:0] cnt, last;
  logic next_ew, done, ped, idle_bits;
  logic [2:0] idle_light;
  assign last = (state == NS_G || state == EW_G) ? CNT_W'(GREEN_T - 1) :
                (state == NS_Y || state == EW_Y) ? CNT_W'(YELLOW_T - 1) :
                (state == AR1 || state == AR2) ? CNT_W'(ALL_RED_T - 1) : CNT_W'(WALK_T - 1);
  assign done = cnt == last;
  assign ped = ped_pending | ped_req;
  // next-state: en low always forces IDLE; all-red exits divert to WALK when a request is pending
  always_comb begin
    nxt = state;
    if (!en) nxt = IDLE;
    else case (state)
      IDLE: nxt = NS_G;
      NS_G: nxt = done ? NS_Y : NS_G;
      NS_Y: nxt = done ? AR1 : NS_Y;
      AR1:  nxt = done ? (ped ? WALK : EW_G) : AR1;
      EW_G: nxt = done ? EW_Y : EW_G;
      EW_Y: nxt = done ? AR2 : EW_Y;
      AR2:  nxt = done ? (ped ? WALK : NS_G) : AR2;
      WALK: nxt = done ? (next_ew ? EW_G : NS_G) : WALK;
      default: nxt = IDLE;
    endcase
  end
  // state, phase counter, pedestrian latch and walk-return direction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ped_pending <= 1'b0;
      next_ew <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
      ped_pending <= (nxt == WALK && state != WALK) ? 1'b0 : ped_pending | (ped_req && state != WALK);
      next_ew <= (state == AR1 && done) ? 1'b1 : (state == AR2 && done) ? 1'b0 : next_ew;
    end
  end
`ifdef TL_FLASH_IDLE_EN
  logic flash;
  logic [CNT_W-1:0] fcnt;
  // idle flash toggle, held clear whenever the junction is not resting in IDLE
  always_ff @(posedge clk) begin
    if (rst || state != IDLE || nxt != IDLE) begin
      flash <= 1'b0;
      fcnt <= '0;
    end else if (fcnt == CNT_W'(FLASH_HALF_T - 1)) begin
      flash <= ~flash;
      fcnt <= '0;
    end else fcnt <= fcnt + 1'b1;
  end
  assign idle_bits = flash;
  assign idle_light = {1'b0, flash, 1'b0};
`else
  assign idle_bits = 1'b0;
  assign idle_light = 3'b100;
`endif
  // Moore decode of the state register
  always_comb begin
    ns_light = state == NS_G ? 3'b001 : state == NS_Y ? 3'b010 : state == IDLE ? idle_light : 3'b100;
    ew_light = state == EW_G ? 3'b001 : state == EW_Y ? 3'b010 : state == IDLE ? idle_light : 3'b100;
    walk = state == WALK;
    phase = state;
  end
  logic unused_ok;
  assign unused_ok = idle_bits;
endmodule

// File: doc/traffic_light_junction.md
# traffic_light_junction

Parametrised two-road junction controller, successor to the single-signal traffic light. Drives north-south (NS) and east-west (EW) signal heads through a fixed green→yellow→all-red rotation with programmable phase lengths. Adds a latched pedestrian-request path that inserts a walk phase, plus an optional flashing-yellow idle mode. Sits at top level beside the lamp drivers; `en` comes from the system controller and `ped_req` from the debounced push-button block.

## Interface
- `CNT_W`, 8: phase-counter width; every `*_T` must satisfy 1 ≤ T ≤ 2^CNT_W−1.
- `GREEN_T`, 20: green phase length, cycles.
- `YELLOW_T`, 4: yellow phase length, cycles.
- `ALL_RED_T`, 2: all-red clearance length, cycles.
- `WALK_T`, 10: pedestrian walk phase length, cycles.
- `FLASH_HALF_T`, 5: half-period of idle flash, cycles (used only with the configuration macro).
---
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable; low forces IDLE.
- `ped_req` in 1: pedestrian request, level sampled every cycle.
- `ns_light` out 3: NS head {red, yellow, green}.
- `ew_light` out 3: EW head {red, yellow, green}.
- `walk` out 1: pedestrian walk lamp.
- `ped_pending` out 1: request latched, not yet served.
- `phase` out 3: current state encoding.

## Operation
- States/encoding: IDLE=0, NS_G=1, NS_Y=2, AR1=3, EW_G=4, EW_Y=5, AR2=6, WALK=7.
- Outputs are a Moore decode of the state register. NS_G: ns=100→001 i.e. ns=001, ew=100. NS_Y: ns=010, ew=100. EW_G: ns=100, ew=001. EW_Y: ns=100, ew=010. AR1/AR2/WALK: ns=ew=100. `walk`=1 only in WALK. IDLE: ns=ew=100 (see Configuration).
- Phase counter `cnt` (CNT_W bits) clears on every state entry and increments each cycle. A state of length T exits on the edge where `cnt==T−1`; it therefore lasts exactly T cycles.
- Transitions: IDLE→NS_G when `en`=1. NS_G→NS_Y→AR1. AR1→EW_G, or AR1→WALK if pedestrian pending. EW_G→EW_Y→AR2. AR2→NS_G, or AR2→WALK if pending. WALK→EW_G if entered from AR1, →NS_G if entered from AR2 (1-bit `next_ew` register, set on AR1 exit).
- Pedestrian latch: `ped_pending` sets on any cycle with `ped_req`=1 outside WALK. It clears on the edge entering WALK. `ped_req` during WALK is ignored. Pending test at all-red exit uses `ped_pending | ped_req`, so a request in the final all-red cycle is served.
- `en`=0 in any state: the next edge goes to IDLE with `cnt`=0; `ped_pending` is retained. Re-enable always restarts at NS_G.
- No other state is reachable. Any illegal encoding returns to IDLE.

## Timing
- Reset values: state IDLE, `cnt`=0, `ped_pending`=0, `next_ew`=0, flash toggle 0, `walk`=0, `phase`=0. `ns_light`/`ew_light` are 100 without the macro and 000 with it.
- `en` sampled high at edge k gives NS_G outputs visible after edge k.
- Full rotation without pedestrian requests is 2·(GREEN_T+YELLOW_T+ALL_RED_T) cycles. A walk insertion adds WALK_T.
- `rst` has priority over `en`. Reset mid-phase returns to IDLE on the next edge regardless of state.

## Configuration
- `TL_FLASH_IDLE_EN` defined: in IDLE a toggle register inverts every FLASH_HALF_T cycles. ns=ew=010 while the toggle is 1 and 000 while it is 0. The toggle and its counter clear on leaving IDLE.
- Undefined: IDLE shows solid all-red (ns=ew=100) and the flash logic is absent.

## Test plan
Default parameters for the bench: GREEN_T=3, YELLOW_T=2, ALL_RED_T=1, WALK_T=2.
- Reset then `en`=1 held → phase sequence 1,1,1,2,2,3,4,4,4,5,5,6, repeating with period 12; ns/ew decode matches per state.
- `ped_req` pulsed 1 cycle during NS_G → `ped_pending`=1 next cycle. The sequence is then AR1 (1 cycle), WALK for 2 cycles with `walk`=1, `ped_pending` back to 0, then EW_G.
- `ped_req` asserted only in the single AR2 cycle → WALK follows AR2, then NS_G. Total rotation that cycle is 14.
- `en` dropped mid-EW_G with `ped_pending`=1 → IDLE next edge. On re-enable, NS_G lasts the full 3 cycles and WALK is inserted at the next AR1.
- `rst` pulsed during WALK → next edge shows phase=0, `walk`=0 and `ped_pending`=0.
- With `TL_FLASH_IDLE_EN` and FLASH_HALF_T=5, `en`=0 → ns=ew=000 for 5 cycles, then 010 for 5 cycles, alternating. Without the macro the lights stay at 100.
